aes128_iter_core: RTL and testbench

// - Iterative AES-128 encryption engine (FIPS-197).
// - Encrypts a fixed plaintext under a 128-bit key supplied on key; one round per clock.
// - Top-level DUT of the AES benchmark: key plus a 1-bit start strobe in, ciphertext out.
// - Instantiated by the bench under the module name top.

---
 rtl/aes128_iter_core.sv | 182 ++++++++++++++++++
 tb/tb_aes128_iter_core.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryption core: one round per clock, fixed plaintext.
// A one-cycle start strobe latches the key; the ciphertext is registered on
// the edge that applies round 10.
// Optional build macro: AES_RESTART_EN -- a start strobe seen while busy
// restarts the encryption with the current key instead of being ignored.

// S-box for a single byte: multiplicative inverse in GF(2^8), then affine map.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p;
    logic [7:0] s;
    p = 8'h00;
    s = x;
    for (int i = 0; i < 8; i++) begin
      if (z[i]) p = p ^ s;
      s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;

  // x^254 gives the inverse (and maps 0 to 0); addition chain 2,3,6,12,15,...,240,254
  always_comb begin
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    y    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

module aes128_iter_core #(
  parameter logic [127:0] PLAINTEXT = 128'h00112233445566778899aabbccddeeff
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key,
  input  logic         __obs,
  output logic [127:0] out
);

  typedef enum logic {IDLE, BUSY} fsm_t;

  fsm_t         fsm;
  logic [127:0] st;
  logic [127:0] rk;
  logic [3:0]   rnd;

  logic [15:0][7:0] sb_b;   // SubBytes result, index = AES byte number
  logic [15:0][7:0] sr_b;   // after ShiftRows
  logic [15:0][7:0] mc_b;   // after MixColumns
  logic [3:0][7:0]  ks_in;  // RotWord(w3) bytes
  logic [3:0][7:0]  ks_out; // SubWord of the above
  logic [7:0]       rcon;
  logic [127:0]     nrk;
  logic [127:0]     round_res;

  function automatic logic [7:0] xt(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  // 16 state S-boxes plus 4 key-schedule S-boxes, all active every cycle
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_sb
      aes_sbox u_sb (.a(st[127-8*gi -: 8]), .y(sb_b[gi]));
    end
    for (gi = 0; gi < 4; gi++) begin : g_ks
      aes_sbox u_ks (.a(ks_in[gi]), .y(ks_out[gi]));
    end
  endgenerate

  // round constant selected by the round about to be applied
  always_comb begin
    case (rnd)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // next round key from the current one: w0' = w0 ^ SubWord(RotWord(w3)) ^ Rcon
  always_comb begin
    logic [31:0] rot, tmp, w0, w1, w2, w3;
    rot = {rk[23:0], rk[31:24]};
    for (int j = 0; j < 4; j++) ks_in[j] = rot[31-8*j -: 8];
    tmp = {ks_out[0], ks_out[1], ks_out[2], ks_out[3]} ^ {rcon, 24'h000000};
    w0  = rk[127:96] ^ tmp;
    w1  = rk[95:64]  ^ w0;
    w2  = rk[63:32]  ^ w1;
    w3  = rk[31:0]   ^ w2;
    nrk = {w0, w1, w2, w3};
  end

  // ShiftRows, MixColumns (bypassed in the last round), AddRoundKey
  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    sr_b      = '0;
    mc_b      = '0;
    round_res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr_b[4*c+r] = sb_b[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      a0 = sr_b[4*c];
      a1 = sr_b[4*c+1];
      a2 = sr_b[4*c+2];
      a3 = sr_b[4*c+3];
      mc_b[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      mc_b[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      mc_b[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      mc_b[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    for (int i = 0; i < 16; i++)
      round_res[127-8*i -: 8] = ((rnd == 4'd10) ? sr_b[i] : mc_b[i]) ^ nrk[127-8*i -: 8];
  end

  // control FSM and datapath registers; out only written on completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm <= IDLE;
      st  <= '0;
      rk  <= '0;
      rnd <= '0;
      out <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (__obs) begin
            st  <= PLAINTEXT ^ key;
            rk  <= key;
            rnd <= 4'd1;
            fsm <= BUSY;
          end
        end
        BUSY: begin
`ifdef AES_RESTART_EN
          if (__obs) begin
            st  <= PLAINTEXT ^ key;
            rk  <= key;
            rnd <= 4'd1;
          end else
`endif
          begin
            rk <= nrk;
            if (rnd == 4'd10) begin
              out <= round_res;
              rnd <= 4'd0;
              fsm <= IDLE;
            end else begin
              st  <= round_res;
              rnd <= rnd + 4'd1;
            end
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_iter_core.sv
// Bench for aes128_iter_core: table of FIPS and random vectors against a
// byte-matrix AES model, plus reset, key churn, held-strobe and abort cases.
module tb_aes128_iter_core;

  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         rst;
  logic         obs;
  logic [127:0] key;
  logic [127:0] out_a, out_b;

  int errors = 0;
  int checks = 0;
  logic [127:0] last_a, last_b;
  logic [7:0]   sbox_t [256];

  always #5 clk = ~clk;

  aes128_iter_core top (.clk(clk), .rst(rst), .key(key), .__obs(obs), .out(out_a));
  aes128_iter_core #(.PLAINTEXT(128'h0)) top_pz (.clk(clk), .rst(rst), .key(key), .__obs(obs), .out(out_b));

  typedef struct {
    logic [127:0] k;
    logic [127:0] ea;
    logic [127:0] eb;
  } vec_t;
  vec_t tbl [8];

  function automatic logic [7:0] xtm(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box table built by walking generator 3 and its inverse; independent of the RTL method
  task automatic build_sbox();
    logic [7:0] p, q;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      sbox_t[p] = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  // textbook AES-128: full key expansion, 4x4 byte matrix rounds
  function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] pt);
    logic [31:0] w [44];
    logic [7:0]  s [4][4];
    logic [7:0]  t [4][4];
    logic [31:0] tmp;
    logic [7:0]  rc;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = xtm(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sbox_t[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          if (rd < 10)
            s[r][c] = xtm(t[r][c]) ^ xtm(t[(r+1)%4][c]) ^ t[(r+1)%4][c] ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
          else
            s[r][c] = t[r][c];
          s[r][c] = s[r][c] ^ w[4*rd+c][31-8*r -: 8];
        end
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(4*c+r) -: 8] = s[r][c];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one-cycle start; output must hold at N+9 and update at N+10
  task automatic run_enc(input string tag, input logic [127:0] k, input logic [127:0] ea,
                         input logic [127:0] eb, input bit churn);
    obs = 1'b1;
    key = k;
    tick();
    obs = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (churn) key = rnd128();
      tick();
    end
    chk({tag, " hold_a"}, out_a, last_a);
    chk({tag, " hold_b"}, out_b, last_b);
    tick();
    chk({tag, " done_a"}, out_a, ea);
    chk({tag, " done_b"}, out_b, eb);
    last_a = ea;
    last_b = eb;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k2, kr;
    build_sbox();
    rst = 1'b0;
    obs = 1'b0;
    key = '0;

    // reset held with inputs toggling
    for (int i = 0; i < 4; i++) begin
      key = rnd128();
      obs = i[0];
      tick();
      chk($sformatf("reset_hold%0d", i), out_a, 128'h0);
    end
    chk("reset_hold_b", out_b, 128'h0);
    obs = 1'b0;
    rst = 1'b1;
    repeat (12) tick();
    chk("post_reset_idle_a", out_a, 128'h0);
    chk("post_reset_idle_b", out_b, 128'h0);
    last_a = '0;
    last_b = '0;

    // vector table: FIPS C.1, all-zero key, random keys
    tbl[0].k = K_C1; tbl[0].ea = C_C1;              tbl[0].eb = aes_ref(K_C1, 128'h0);
    tbl[1].k = '0;   tbl[1].ea = aes_ref('0, PT);   tbl[1].eb = C_Z;
    for (int i = 2; i < 8; i++) begin
      tbl[i].k  = rnd128();
      tbl[i].ea = aes_ref(tbl[i].k, PT);
      tbl[i].eb = aes_ref(tbl[i].k, 128'h0);
    end
    for (int i = 0; i < 8; i++) begin
      run_enc($sformatf("vec%0d", i), tbl[i].k, tbl[i].ea, tbl[i].eb, 1'b0);
      if (i[0]) tick();   // mix back-to-back starts with an idle gap
    end

    // key changes during the run must not matter
    run_enc("key_churn", K_C1, C_C1, aes_ref(K_C1, 128'h0), 1'b1);

    // strobe held high for 15 edges, key switched after edge N+10
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    k2 = rnd128();
    for (int e = 0; e <= 24; e++) begin
      obs = (e < 15);
      key = (e <= 10) ? K_C1 : k2;
      tick();
`ifdef AES_RESTART_EN
      if (e == 10) chk("held_e10", out_a, 128'h0);
      if (e == 23) chk("held_e23", out_a, 128'h0);
      if (e == 24) chk("held_e24", out_a, aes_ref(k2, PT));
`else
      if (e == 9)  chk("held_e9",  out_a, 128'h0);
      if (e == 10) chk("held_e10", out_a, C_C1);
      if (e == 20) chk("held_e20", out_a, C_C1);
      if (e == 21) chk("held_e21", out_a, aes_ref(k2, PT));
      if (e == 21) chk("held_e21_b", out_b, aes_ref(k2, 128'h0));
`endif
    end
    obs = 1'b0;

    // abort at round 5: out clears at once and no completion follows
    obs = 1'b1;
    key = K_C1;
    tick();
    obs = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    #1;
    chk("abort_clear_a", out_a, 128'h0);
    chk("abort_clear_b", out_b, 128'h0);
    tick();
    rst = 1'b1;
    repeat (12) tick();
    chk("abort_no_done", out_a, 128'h0);
    last_a = '0;
    last_b = '0;
    kr = rnd128();
    run_enc("after_abort", kr, aes_ref(kr, PT), aes_ref(kr, 128'h0), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
